// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: shuffles an external 2^ADDR_W-entry S-box RAM with a runtime-length key.
// Define RC4_KSA_INIT_PHASE_EN to fill the RAM with the identity permutation in-engine; otherwise it must be preloaded.
module rc4_ksa_engine #(
   parameter int DATA_W        = 8,
   parameter int ADDR_W        = 8,
   parameter int MAX_KEY_BYTES = 16,
   localparam int KL_W         = $clog2(MAX_KEY_BYTES + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            abort,
   input  logic [KL_W-1:0]                 key_len,
   input  logic [MAX_KEY_BYTES*DATA_W-1:0] key,
   input  logic [DATA_W-1:0]               ram_rdata,
   output logic [ADDR_W-1:0]               ram_addr,
   output logic [DATA_W-1:0]               ram_wdata,
   output logic                            ram_we,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   localparam int KEY_W = MAX_KEY_BYTES * DATA_W;
   localparam int SUM_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   // start is a one-cycle request that is only looked at in IDLE; busy is high in
   // every other state, and done / err are single-cycle pulses with no handshake.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
`ifdef RC4_KSA_INIT_PHASE_EN
      INIT = 3'd1,
`endif
      RD_I = 3'd2,
      RD_J = 3'd3,
      WR_I = 3'd4,
      WR_J = 3'd5,
      FIN  = 3'd6
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   i;
   logic [ADDR_W-1:0]   j;
   logic [KL_W-1:0]     k;
   logic [DATA_W-1:0]   si;
   logic [KEY_W-1:0]    key_r;
   logic [KL_W-1:0]     key_len_r;

   logic [DATA_W-1:0]   key_byte;
   logic [SUM_W-1:0]    j_sum;
   logic [ADDR_W-1:0]   jn;
   logic                key_len_ok;

   assign key_len_ok = (key_len != '0) && (key_len <= KL_W'(MAX_KEY_BYTES));

   always_comb begin
      key_byte = '0;
      for (int b = 0; b < MAX_KEY_BYTES; b++) begin
         if (k == KL_W'(b)) key_byte = key_r[b*DATA_W +: DATA_W];
      end
   end

   // The sum is taken at the wider of the two widths; only its low ADDR_W bits matter.
   always_comb begin
      j_sum = SUM_W'(j) + SUM_W'(ram_rdata) + SUM_W'(key_byte);
      jn    = j_sum[ADDR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         si        <= '0;
         key_r     <= '0;
         key_len_r <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (state != IDLE && abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (key_len_ok) begin
                        key_r     <= key;
                        key_len_r <= key_len;
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        busy      <= 1'b1;
`ifdef RC4_KSA_INIT_PHASE_EN
                        state     <= INIT;
`else
                        state     <= RD_I;
`endif
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
`ifdef RC4_KSA_INIT_PHASE_EN
               INIT: begin
                  i <= i + 1'b1;
                  if (i == '1) state <= RD_I;
               end
`endif
               RD_I: state <= RD_J;
               RD_J: begin
                  si    <= ram_rdata;
                  j     <= jn;
                  state <= WR_I;
               end
               WR_I: state <= WR_J;
               WR_J: begin
                  i <= i + 1'b1;
                  k <= (k == key_len_r - 1'b1) ? '0 : k + 1'b1;
                  if (i == '1) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= RD_I;
                  end
               end
               FIN: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // RAM port decode; WR_I forwards s[j], which the RAM returns for the address issued in RD_J.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      case (state)
`ifdef RC4_KSA_INIT_PHASE_EN
         INIT: begin
            ram_addr  = i;
            ram_wdata = DATA_W'(i);
            ram_we    = 1'b1;
         end
`endif
         RD_I: ram_addr = i;
         RD_J: ram_addr = jn;
         WR_I: begin
            ram_addr  = i;
            ram_wdata = ram_rdata;
            ram_we    = 1'b1;
         end
         WR_J: begin
            ram_addr  = j;
            ram_wdata = si;
            ram_we    = 1'b1;
         end
         default: begin
            ram_addr  = '0;
            ram_wdata = '0;
            ram_we    = 1'b0;
         end
      endcase
   end

   a_we_only_busy   : assert property (@(posedge clk) disable iff (reset) ram_we |-> busy);
   a_done_only_busy : assert property (@(posedge clk) disable iff (reset) done |-> busy);
   a_err_only_idle  : assert property (@(posedge clk) disable iff (reset) err |-> !busy);

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: behavioural RAM, software RC4 KSA reference, scenario tasks.
`timescale 1ns/1ps
module tb_rc4_ksa_engine;

   localparam int DATA_W        = 8;
   localparam int ADDR_W        = 8;
   localparam int MAX_KEY_BYTES = 16;
   localparam int KL_W          = $clog2(MAX_KEY_BYTES + 1);
   localparam int KEY_W         = MAX_KEY_BYTES * DATA_W;
   localparam int N             = 1 << ADDR_W;
`ifdef RC4_KSA_INIT_PHASE_EN
   localparam int INIT_CYC      = N;
`else
   localparam int INIT_CYC      = 0;
`endif
   localparam int RUN_DONE      = INIT_CYC + 4 * N + 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                abort;
   logic [KL_W-1:0]     key_len;
   logic [KEY_W-1:0]    key;
   logic [DATA_W-1:0]   ram_rdata;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic                ram_we;
   logic                busy;
   logic                done;
   logic                err;

   int n_checks = 0;
   int n_errors = 0;

   rc4_ksa_engine #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_KEY_BYTES(MAX_KEY_BYTES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .key_len(key_len), .key(key), .ram_rdata(ram_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .busy(busy), .done(done), .err(err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- RAM model: one-cycle read latency, write log ----------------
   logic [DATA_W-1:0]        mem     [N];
   logic [DATA_W-1:0]        pre_mem [N];
   logic                     preload = 1'b0;
   logic [ADDR_W+DATA_W-1:0] wr_q[$];

   always @(posedge clk) begin
      if (preload) begin
         for (int a = 0; a < N; a++) mem[a] <= pre_mem[a];
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wr_q.push_back({ram_addr, ram_wdata});
      end
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- reference model: textbook RC4 KSA ----------------
   logic [DATA_W-1:0] exp_q[$];

   task automatic model_ksa(input int kl, input logic [KEY_W-1:0] kv);
      int s [N];
      int jj, t, kb;
      for (int a = 0; a < N; a++) s[a] = a;
      jj = 0;
      for (int a = 0; a < N; a++) begin
         kb = int'(DATA_W'(kv >> ((a % kl) * DATA_W)));
         jj = (jj + s[a] + kb) % N;
         t = s[a]; s[a] = s[jj]; s[jj] = t;
      end
      exp_q.delete();
      for (int a = 0; a < N; a++) exp_q.push_back(DATA_W'(s[a]));
   endtask

   function automatic int ram_diff();
      int bad = 0;
      for (int a = 0; a < N; a++) if (mem[a] !== exp_q[a]) bad++;
      return bad;
   endfunction

   function automatic logic [KEY_W-1:0] rand_key();
      logic [KEY_W-1:0] kv = '0;
      for (int w = 0; w < KEY_W / 32; w++) kv = (kv << 32) | KEY_W'($urandom());
      return kv;
   endfunction

   // ---------------- drivers ----------------
   task automatic prepare_ram();
      for (int a = 0; a < N; a++) begin
`ifdef RC4_KSA_INIT_PHASE_EN
         pre_mem[a] = DATA_W'($urandom());
`else
         pre_mem[a] = DATA_W'(a);
`endif
      end
      @(posedge clk); #1; preload = 1'b1;
      @(posedge clk); #1; preload = 1'b0;
   endtask

   int r_done_cyc, r_n_done, r_busy_bad, r_busy_late, r_err, r_late_wr;

   // start is driven in cycle 0; observations are taken per cycle at the falling edge
   task automatic do_run(input int kl, input logic [KEY_W-1:0] kv, input int abort_at, input int inject_at);
      int stop, late_from, wsz;
      r_done_cyc = -1; r_n_done = 0; r_busy_bad = 0; r_busy_late = 0; r_err = 0; r_late_wr = 0;
      wsz       = wr_q.size();
      stop      = (abort_at > 0) ? abort_at : RUN_DONE - 1;
      late_from = (abort_at > 0) ? abort_at + 1 : RUN_DONE + 1;
      @(posedge clk); #1;
      start = 1'b1; key_len = KL_W'(kl); key = kv;
      for (int c = 1; c <= RUN_DONE + 8; c++) begin
         @(posedge clk); #1;
         start = (c == inject_at);
         if (c == inject_at) begin
            key_len = '0;
            key     = rand_key();
         end
         abort = (abort_at > 0 && c == abort_at);
         @(negedge clk);
         if (done === 1'b1) begin
            r_n_done++;
            if (r_done_cyc < 0) r_done_cyc = c;
         end
         if (err === 1'b1) r_err++;
         if (c <= stop && busy !== 1'b1) r_busy_bad++;
         if (c >= late_from && busy !== 1'b0) r_busy_late++;
         if (c == late_from) wsz = wr_q.size();
      end
      r_late_wr = wr_q.size() - wsz;
      abort = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; key_len = '0; key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (ram_addr !== '0)   begin n_errors++; $display("FAIL reset_addr: got %h required 0", ram_addr); end
      n_checks++; if (ram_wdata !== '0)  begin n_errors++; $display("FAIL reset_wdata: got %h required 0", ram_wdata); end
      n_checks++; if (ram_we !== 1'b0)   begin n_errors++; $display("FAIL reset_we: got %b required 0", ram_we); end
      n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (done !== 1'b0)     begin n_errors++; $display("FAIL reset_done: got %b required 0", done); end
      n_checks++; if (err !== 1'b0)      begin n_errors++; $display("FAIL reset_err: got %b required 0", err); end
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_release_busy: got %b required 0", busy); end
   endtask

   task automatic test_known_key();
      int base, nbad;
      logic [KEY_W-1:0] kv;
      kv = KEY_W'(24'h030201);
      prepare_ram();
      model_ksa(3, kv);
      base = wr_q.size();
      do_run(3, kv, 0, 0);
      n_checks++; if (r_done_cyc !== RUN_DONE) begin n_errors++; $display("FAIL known_done_cycle: got %0d required %0d", r_done_cyc, RUN_DONE); end
      n_checks++; if (r_n_done !== 1)          begin n_errors++; $display("FAIL known_done_pulses: got %0d required 1", r_n_done); end
      n_checks++; if (r_busy_bad !== 0)        begin n_errors++; $display("FAIL known_busy_low_in_run: got %0d cycles required 0", r_busy_bad); end
      n_checks++; if (r_busy_late !== 0)       begin n_errors++; $display("FAIL known_busy_after_done: got %0d cycles required 0", r_busy_late); end
      n_checks++; if (r_late_wr !== 0)         begin n_errors++; $display("FAIL known_writes_after_done: got %0d required 0", r_late_wr); end
      n_checks++; if (wr_q.size() - base !== INIT_CYC + 2 * N)
         begin n_errors++; $display("FAIL known_write_count: got %0d required %0d", wr_q.size() - base, INIT_CYC + 2 * N); end
      n_checks++; if (wr_q[base + INIT_CYC] !== 16'h0001)
         begin n_errors++; $display("FAIL known_first_write: got %h required 0001", wr_q[base + INIT_CYC]); end
      n_checks++; if (wr_q[base + INIT_CYC + 1] !== 16'h0100)
         begin n_errors++; $display("FAIL known_second_write: got %h required 0100", wr_q[base + INIT_CYC + 1]); end
`ifdef RC4_KSA_INIT_PHASE_EN
      nbad = 0;
      for (int a = 0; a < N; a++)
         if (wr_q[base + a] !== {ADDR_W'(a), DATA_W'(a)}) nbad++;
      n_checks++; if (nbad !== 0) begin n_errors++; $display("FAIL known_init_writes: got %0d bad required 0", nbad); end
`endif
      nbad = ram_diff();
      n_checks++; if (nbad !== 0) begin n_errors++; $display("FAIL known_ram: got %0d differing entries required 0", nbad); end
   endtask

   task automatic test_bad_key_len();
      int lens [2] = '{0, MAX_KEY_BYTES + 1};
      int errs, e1, busy_hi, wsz;
      foreach (lens[n]) begin
         @(posedge clk); #1;
         start = 1'b1; key_len = KL_W'(lens[n]); key = rand_key();
         wsz = wr_q.size(); errs = 0; e1 = 0; busy_hi = 0;
         for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            if (err === 1'b1) errs++;
            if (c == 1 && err === 1'b1) e1 = 1;
            if (busy !== 1'b0) busy_hi++;
         end
         n_checks++; if (errs !== 1)   begin n_errors++; $display("FAIL badlen%0d_err_pulses: got %0d required 1", lens[n], errs); end
         n_checks++; if (e1 !== 1)     begin n_errors++; $display("FAIL badlen%0d_err_timing: got %0d required 1", lens[n], e1); end
         n_checks++; if (busy_hi !== 0) begin n_errors++; $display("FAIL badlen%0d_busy: got %0d cycles required 0", lens[n], busy_hi); end
         n_checks++; if (wr_q.size() !== wsz) begin n_errors++; $display("FAIL badlen%0d_writes: got %0d required 0", lens[n], wr_q.size() - wsz); end
      end
   endtask

   task automatic test_abort();
      int nbad;
      prepare_ram();
      do_run(MAX_KEY_BYTES, rand_key(), 600, 0);
      n_checks++; if (r_n_done !== 0)    begin n_errors++; $display("FAIL abort_done: got %0d pulses required 0", r_n_done); end
      n_checks++; if (r_busy_bad !== 0)  begin n_errors++; $display("FAIL abort_busy_before: got %0d cycles required 0", r_busy_bad); end
      n_checks++; if (r_busy_late !== 0) begin n_errors++; $display("FAIL abort_idle_after: got %0d busy cycles required 0", r_busy_late); end
      n_checks++; if (r_late_wr !== 0)   begin n_errors++; $display("FAIL abort_writes_after: got %0d required 0", r_late_wr); end
      prepare_ram();
      model_ksa(1, '0);
      do_run(1, '0, 0, 0);
      n_checks++; if (r_done_cyc !== RUN_DONE) begin n_errors++; $display("FAIL restart_done_cycle: got %0d required %0d", r_done_cyc, RUN_DONE); end
      nbad = ram_diff();
      n_checks++; if (nbad !== 0) begin n_errors++; $display("FAIL restart_ram: got %0d differing entries required 0", nbad); end
   endtask

   task automatic test_start_while_busy();
      int kl, nbad;
      logic [KEY_W-1:0] kv;
      kl = $urandom_range(1, MAX_KEY_BYTES);
      kv = rand_key();
      prepare_ram();
      model_ksa(kl, kv);
      do_run(kl, kv, 0, 100);
      n_checks++; if (r_err !== 0)             begin n_errors++; $display("FAIL busy_start_err: got %0d pulses required 0", r_err); end
      n_checks++; if (r_done_cyc !== RUN_DONE) begin n_errors++; $display("FAIL busy_start_done_cycle: got %0d required %0d", r_done_cyc, RUN_DONE); end
      nbad = ram_diff();
      n_checks++; if (nbad !== 0) begin n_errors++; $display("FAIL busy_start_ram: got %0d differing entries required 0", nbad); end
   endtask

   task automatic test_reset_mid_run();
      prepare_ram();
      @(posedge clk); #1;
      start = 1'b1; key_len = KL_W'(MAX_KEY_BYTES); key = rand_key();
      repeat (400) begin @(posedge clk); #1; start = 1'b0; end
      reset = 1'b1; abort = 1'b1; start = 1'b1; key_len = KL_W'(4);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midrun_busy_before: got %b required 1", busy); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (ram_addr !== '0)  begin n_errors++; $display("FAIL midrun_reset_addr: got %h required 0", ram_addr); end
      n_checks++; if (ram_wdata !== '0) begin n_errors++; $display("FAIL midrun_reset_wdata: got %h required 0", ram_wdata); end
      n_checks++; if (ram_we !== 1'b0)  begin n_errors++; $display("FAIL midrun_reset_we: got %b required 0", ram_we); end
      n_checks++; if (busy !== 1'b0)    begin n_errors++; $display("FAIL midrun_reset_busy: got %b required 0", busy); end
      n_checks++; if (done !== 1'b0)    begin n_errors++; $display("FAIL midrun_reset_done: got %b required 0", done); end
      n_checks++; if (err !== 1'b0)     begin n_errors++; $display("FAIL midrun_reset_err: got %b required 0", err); end
      @(posedge clk); #1;
      reset = 1'b0; abort = 1'b0; start = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrun_release_busy: got %b required 0", busy); end
   endtask

   task automatic test_random_keys();
      int kl, nbad;
      logic [KEY_W-1:0] kv;
      for (int r = 0; r < 3; r++) begin
         kl = (r == 0) ? MAX_KEY_BYTES : $urandom_range(1, MAX_KEY_BYTES);
         kv = rand_key();
         prepare_ram();
         model_ksa(kl, kv);
         do_run(kl, kv, 0, 0);
         n_checks++; if (r_done_cyc !== RUN_DONE) begin n_errors++; $display("FAIL rand%0d_done_cycle: got %0d required %0d", r, r_done_cyc, RUN_DONE); end
         n_checks++; if (r_n_done !== 1)          begin n_errors++; $display("FAIL rand%0d_done_pulses: got %0d required 1", r, r_n_done); end
         nbad = ram_diff();
         n_checks++; if (nbad !== 0) begin n_errors++; $display("FAIL rand%0d_ram_len%0d: got %0d differing entries required 0", r, kl, nbad); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_known_key();
      test_bad_key_len();
      test_abort();
      test_start_while_busy();
      test_reset_mid_run();
      test_random_keys();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
